// File: rtl/simple_pkg.sv
// Shared definitions for the SIMPLE core: datapath width, the NOP encoding
// and the instruction-fetch state encoding.
package simple_pkg;

    localparam int              WIDTH    = 16;
    localparam logic [WIDTH-1:0] NOP_INSN = 16'h0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid.sv
// One-entry instruction + return-address holding buffer used by the fetch
// stage to park a memory response while decode is stalled.
module fetch_skid #(
    parameter int W = simple_pkg::WIDTH
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load_i,
    input  logic         unload_i,
    input  logic         clear_i,
    input  logic [W-1:0] data_i,
    input  logic [W-1:0] pc_i,
    output logic [W-1:0] data_o,
    output logic [W-1:0] pc_o
);

    logic [W-1:0] data_q;
    logic [W-1:0] pc_q;

    // Occupancy is tracked by the owning FSM; emptying the entry keeps stale
    // words from being mistaken for live ones when inspecting state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
            pc_q   <= '0;
        end else if (clear_i || unload_i) begin
            data_q <= '0;
            pc_q   <= '0;
        end else if (load_i) begin
            data_q <= data_i;
            pc_q   <= pc_i;
        end
    end

    assign data_o = data_q;
    assign pc_o   = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues one-cycle-latency imem reads at the current
// PC, fills the IR pipeline register, absorbs decode stalls and branch flushes.
module fetch_stage #(
    parameter int               WIDTH    = simple_pkg::WIDTH,
    parameter logic [WIDTH-1:0] NOP_INSN = simple_pkg::NOP_INSN
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] pcPlusOne,
    input  logic             branchFlag,
    input  logic             stall,
    output logic             imemReq,
    output logic [WIDTH-1:0] imemAddr,
    input  logic [WIDTH-1:0] imemRdata,
    output logic             ce,
    output logic [WIDTH-1:0] ir,
    output logic [WIDTH-1:0] irPc,
    output logic             irValid
);

    import simple_pkg::*;

    fetch_state_e     state_q, state_d;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_pc_q;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0] ir_pc_q, ir_pc_d;
    logic             ir_valid_q, ir_valid_d;

    logic             skid_load, skid_unload, skid_clear;
    logic [WIDTH-1:0] skid_data, skid_pc;

    assign imemAddr = pc;
    assign imemReq  = (state_q == S_RUN) && !stall && !branchFlag;
    assign ce       = imemReq || branchFlag;

    fetch_skid #(.W(WIDTH)) u_skid (
        .clock    (clock),
        .reset    (reset),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .clear_i  (skid_clear),
        .data_i   (imemRdata),
        .pc_i     (rsp_pc_q),
        .data_o   (skid_data),
        .pc_o     (skid_pc)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves one unassigned and infers a latch.
        state_d     = state_q;
        ir_d        = ir_q;
        ir_pc_d     = ir_pc_q;
        ir_valid_d  = ir_valid_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;

        if (branchFlag) begin
            state_d    = S_RUN;
            ir_d       = NOP_INSN;
            ir_valid_d = 1'b0;
            skid_clear = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_RUN;
                S_RUN: begin
                    if (stall) begin
                        // At most one response can be in flight when a stall hits.
                        if (rsp_valid_q) begin
                            skid_load = 1'b1;
                            state_d   = S_HOLD;
                        end
                    end else if (rsp_valid_q) begin
                        ir_d       = imemRdata;
                        ir_pc_d    = rsp_pc_q;
                        ir_valid_d = 1'b1;
                    end else begin
                        ir_valid_d = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        ir_d        = skid_data;
                        ir_pc_d     = skid_pc;
                        ir_valid_d  = 1'b1;
                        skid_unload = 1'b1;
                        state_d     = S_RUN;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_pc_q    <= '0;
            ir_q        <= NOP_INSN;
            ir_pc_q     <= '0;
            ir_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= imemReq;
            if (imemReq) rsp_pc_q <= pcPlusOne;
            ir_q        <= ir_d;
            ir_pc_q     <= ir_pc_d;
            ir_valid_q  <= ir_valid_d;
        end
    end

    assign ir      = ir_q;
    assign irPc    = ir_pc_q;
    assign irValid = ir_valid_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly downstream of the program counter in the 16-bit SIMPLE core.
- Consumes `pc` and `pcPlusOne` from the PC block and drives the PC's `ce` (change-enable).
- Reads instruction memory with a fixed 1-cycle synchronous latency and presents instruction plus return address in the IR pipeline register to decode.
- Handles decode back-pressure with a one-entry skid buffer, and flushes on a taken branch.

Parameters:
- WIDTH, 16, width of instruction words, PC and addresses.
- NOP_INSN, 16'h0000, value loaded into `ir` on reset and flush.

Ports:
- clock  in  1  single clock, all state on its rising edge
- reset  in  1  asynchronous, active-low reset
- pc  in  WIDTH  current PC from the PC block
- pcPlusOne  in  WIDTH  pc+1 from the PC block
- branchFlag  in  1  taken branch resolved this cycle (same net feeding the PC block)
- stall  in  1  decode cannot accept a new IR this cycle
- imemReq  out  1  instruction memory read enable
- imemAddr  out  WIDTH  instruction memory address
- imemRdata  in  WIDTH  read data, valid exactly 1 cycle after imemReq
- ce  out  1  PC advance/load enable to the PC block
- ir  out  WIDTH  fetched instruction
- irPc  out  WIDTH  pc+1 associated with `ir`
- irValid  out  1  `ir` holds a valid instruction

Behaviour:
- Reset (reset=0, asynchronous) values:
  - state=S_IDLE
  - ir=NOP_INSN, irPc=0, irValid=0
  - rspValid=0, rspPc=0, skid=0, skidPc=0
- Combinational outputs are therefore 0 during reset.
- States:
  - S_IDLE: one cycle, no request, then S_RUN.
  - S_RUN: normal fetch.
  - S_HOLD: skid buffer full.
- Combinational outputs:
  - imemAddr=pc
  - imemReq = (state==S_RUN) && !stall && !branchFlag
  - ce = imemReq || branchFlag
  - A PC advance coincides with every issued fetch; a branch always lets the PC load dr.
- Internal response tracking:
  - rspValid <= imemReq
  - rspPc <= pcPlusOne (captured when imemReq)
  - imemRdata is meaningful only when rspValid=1.
- Priority: branchFlag > stall > normal.
- branchFlag=1 (any state), next edge:
  - irValid<=0, ir<=NOP_INSN, rspValid<=0.
  - Response arriving this cycle is discarded; skid is discarded.
  - state<=S_RUN; no fetch issued this cycle.
  - The first fetch of the new target is issued the following cycle.
- S_RUN, rspValid=1, stall=0: ir<=imemRdata, irPc<=rspPc, irValid<=1.
- S_RUN, rspValid=0, stall=0: irValid<=0 (bubble); ir/irPc unchanged.
- S_RUN, stall=1:
  - ir/irPc/irValid held.
  - If rspValid=1: skid<=imemRdata, skidPc<=rspPc, state<=S_HOLD.
  - Cannot recur: no request is issued while stalled.
- S_HOLD, stall=1: everything held, no request.
- S_HOLD, stall=0:
  - ir<=skid, irPc<=skidPc, irValid<=1, state<=S_RUN.
  - No request in this cycle (imemReq depends on state); fetch resumes next cycle.
- Throughput: 1 instruction/cycle with no stall.
- Latency: pc presented → ir valid after 2 edges (request edge, response edge).
- No instruction is lost or duplicated across any stall pattern.
- irPc wraps: pc=16'hFFFF gives irPc=16'h0000 (width-truncated, from PC block).
- Reset mid-request: the response is dropped (rspValid cleared); after release, S_IDLE is followed by a fresh fetch at pc.

Decomposition:
- Shared package (`simple_pkg`):
  - WIDTH
  - NOP_INSN
  - fetch state encoding: S_IDLE=2'd0, S_RUN=2'd1, S_HOLD=2'd2
- One natural sub-module, `fetch_skid`: a one-entry data+pc buffer with load/unload/clear.
- FSM and IR register stay in `fetch_stage`.

Test Plan:
- Reset release, pc=0 tied to the PC block, stall=0, imem[0..3]=A0,A1,A2,A3 → after S_IDLE, ir=A0/irPc=1 two cycles after first imemReq, then A1, A2, A3 on consecutive cycles; ce=1 each issue cycle.
- Stall asserted the cycle after fetch of A1 is issued, held 3 cycles → A1 lands in skid, state S_HOLD, ir stays A0, no imemReq; on release ir=A1, irPc=2, then A2 next fetch, no loss or duplicate.
- branchFlag=1 with dr=16'h0040 while A2 response in flight → A2 discarded, irValid=0 next cycle, next issued imemAddr=16'h0040, ir=imem[0x40], irPc=16'h0041.
- branchFlag and stall both 1 in S_HOLD → skid cleared, state S_RUN, ce=1, irValid=0, fetch at target next cycle.
- pc=16'hFFFF fetch → irPc=16'h0000; following imemAddr=16'h0000.
- reset driven low mid-stream between clock edges → outputs zero immediately (asynchronous), irValid=0, ir=NOP_INSN; after release one S_IDLE cycle, then fetch resumes at pc=0.
